// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_ctrl
// Description : Direct-mapped, read-only L1 instruction cache controller.
//               Hits return a word combinationally; a miss stalls fetch,
//               runs one block-read handshake with instruction memory and
//               fills the line. Saturating hit/miss counters are provided.
// Ports       : i_clk/i_rst_n        clock, asynchronous active-low reset
//               i_cpu_req/i_cpu_addr fetch request, word address {tag,idx,off}
//               i_flush              synchronous invalidate-all pulse
//               o_cpu_rdata          fetched word (valid when req & ~stall)
//               o_cpu_stall          request not yet serviceable
//               o_mem_ren            registered block read enable
//               o_mem_block_address  block address of the outstanding miss
//               i_mem_ready/i_mem_din block data valid / block data (word 0 LSB)
//               o_hit_count/o_miss_count saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl #(
   parameter int  WORD_SIZE  = 32,
   parameter int  BLOCK_SIZE = 8,
   parameter int  MEM_SIZE   = 32,
   parameter int  NUM_LINES  = 4,
   parameter int  CNT_WIDTH  = 16,
   localparam int OFF_W      = $clog2(BLOCK_SIZE),
   localparam int IDX_W      = $clog2(NUM_LINES),
   localparam int BADDR_W    = $clog2(MEM_SIZE),
   localparam int TAG_W      = BADDR_W - IDX_W,
   localparam int ADDR_W     = BADDR_W + OFF_W
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_cpu_req,
   input  logic [ADDR_W-1:0]               i_cpu_addr,
   input  logic                            i_flush,
   output logic [WORD_SIZE-1:0]            o_cpu_rdata,
   output logic                            o_cpu_stall,
   output logic                            o_mem_ren,
   output logic [BADDR_W-1:0]              o_mem_block_address,
   input  logic                            i_mem_ready,
   input  logic [WORD_SIZE*BLOCK_SIZE-1:0] i_mem_din,
   output logic [CNT_WIDTH-1:0]            o_hit_count,
   output logic [CNT_WIDTH-1:0]            o_miss_count
);

   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FILL = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Storage: data and tags need no reset, only the valid bits do.
   logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] r_data [NUM_LINES];
   logic [TAG_W-1:0]                     r_tag  [NUM_LINES];
   logic [NUM_LINES-1:0]                 r_valid;

   logic                 r_mem_ren;
   logic [BADDR_W-1:0]   r_mem_block_address;
   logic [CNT_WIDTH-1:0] r_hit_count;
   logic [CNT_WIDTH-1:0] r_miss_count;

   logic [OFF_W-1:0] w_off;
   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic             w_hit;
   logic [IDX_W-1:0] w_fill_idx;
   logic [TAG_W-1:0] w_fill_tag;
   logic             w_count_hit;
   logic             w_start_miss;
   logic             w_fill;

   assign w_off = i_cpu_addr[OFF_W-1:0];
   assign w_idx = i_cpu_addr[OFF_W +: IDX_W];
   assign w_tag = i_cpu_addr[ADDR_W-1 -: TAG_W];
   assign w_hit = r_valid[w_idx] & (r_tag[w_idx] == w_tag);

   // The fill always targets the latched miss address, never the live one.
   assign w_fill_idx = r_mem_block_address[IDX_W-1:0];
   assign w_fill_tag = r_mem_block_address[BADDR_W-1 -: TAG_W];

   assign o_cpu_rdata         = r_data[w_idx][w_off];
   assign o_cpu_stall         = i_cpu_req & (~w_hit | (r_state != S_IDLE));
   assign o_mem_ren           = r_mem_ren;
   assign o_mem_block_address = r_mem_block_address;
   assign o_hit_count         = r_hit_count;
   assign o_miss_count        = r_miss_count;

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      w_count_hit  = 1'b0;
      w_start_miss = 1'b0;
      w_fill       = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A flush edge neither counts a hit nor starts a miss; the
            // request is simply re-evaluated on the following cycle.
            if (i_cpu_req && !i_flush) begin
               if (w_hit) begin
                  w_count_hit = 1'b1;
               end else begin
                  w_start_miss = 1'b1;
                  w_next_state = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (i_mem_ready) begin
               w_fill       = 1'b1;
               w_next_state = S_FILL;
            end
         end
         // One guaranteed low cycle of read-enable between transfers.
         S_FILL:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------- handshake, valid bits, counters
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem_ren           <= 1'b0;
         r_mem_block_address <= '0;
         r_valid             <= '0;
         r_hit_count         <= '0;
         r_miss_count        <= '0;
      end else begin
         r_mem_ren <= (w_next_state == S_REQ);
         if (w_start_miss) begin
            r_mem_block_address <= i_cpu_addr[ADDR_W-1:OFF_W];
         end
         // Flush clears everything, but an in-flight fill on the same edge
         // still marks its own line valid (later assignment wins).
         if (i_flush) begin
            r_valid <= '0;
         end
         if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
         end
         if (w_count_hit && (r_hit_count != {CNT_WIDTH{1'b1}})) begin
            r_hit_count <= r_hit_count + C_CNT_ONE;
         end
         if (w_start_miss && (r_miss_count != {CNT_WIDTH{1'b1}})) begin
            r_miss_count <= r_miss_count + C_CNT_ONE;
         end
      end
   end

   // ------------------------------------------------------- data / tag arrays
   always_ff @(posedge i_clk) begin
      if (w_fill) begin
         r_data[w_fill_idx] <= i_mem_din;
         r_tag[w_fill_idx]  <= w_fill_tag;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_ctrl
// Description : Directed self-checking bench for icache_ctrl. A behavioural
//               memory answers each block read after a fixed latency with
//               word A = 32'h1000_0000 + A.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl;

   localparam int LAT = 16;

   logic         clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_cpu_req = 1'b0;
   logic [7:0]   i_cpu_addr = 8'h00;
   logic         i_flush = 1'b0;
   logic [31:0]  o_cpu_rdata;
   logic         o_cpu_stall;
   logic         o_mem_ren;
   logic [4:0]   o_mem_block_address;
   logic         i_mem_ready = 1'b0;
   logic [255:0] i_mem_din = '0;
   logic [15:0]  o_hit_count;
   logic [15:0]  o_miss_count;

   int checks = 0;
   int errors = 0;
   int lat_cnt = 0;

   icache_ctrl dut (
      .i_clk               (clk),
      .i_rst_n             (i_rst_n),
      .i_cpu_req           (i_cpu_req),
      .i_cpu_addr          (i_cpu_addr),
      .i_flush             (i_flush),
      .o_cpu_rdata         (o_cpu_rdata),
      .o_cpu_stall         (o_cpu_stall),
      .o_mem_ren           (o_mem_ren),
      .o_mem_block_address (o_mem_block_address),
      .i_mem_ready         (i_mem_ready),
      .i_mem_din           (i_mem_din),
      .o_hit_count         (o_hit_count),
      .o_miss_count        (o_miss_count)
   );

   always #5 clk = ~clk;

   // Memory: after LAT cycles of read-enable, present the block for one cycle.
   always @(negedge clk) begin
      if (!o_mem_ren) begin
         lat_cnt     = 0;
         i_mem_ready = 1'b0;
      end else if (!i_mem_ready) begin
         lat_cnt = lat_cnt + 1;
         if (lat_cnt == LAT) begin
            i_mem_ready = 1'b1;
            for (int w = 0; w < 8; w++) begin
               i_mem_din[w*32 +: 32] = 32'h1000_0000 + {24'd0, o_mem_block_address, 3'b000} + w;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] e);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
   endtask

   // Present a missing address, follow the handshake to completion, then let
   // one more edge pass so the retried lookup is counted as a hit.
   task automatic do_miss(input logic [7:0] a, input logic [4:0] eb, input logic fl,
                          input int em, input int eh);
      bit done;
      bit gap;
      i_cpu_req  = 1'b1;
      i_cpu_addr = a;
      #1;
      chk("miss_stall", o_cpu_stall, 1);
      @(negedge clk);
      chk("ren_rise", o_mem_ren, 1);
      chk("miss_baddr", o_mem_block_address, eb);
      chk("miss_cnt_early", o_miss_count, em);
      i_flush = fl;
      done = 0;
      gap  = 0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         i_flush = 1'b0;
         if (!o_cpu_stall) begin
            done = 1;
         end else if (o_mem_ren) begin
            chk("baddr_hold", o_mem_block_address, eb);
         end else begin
            gap = 1;
         end
      end
      chk("fill_timeout", done, 1);
      chk("ren_gap", gap, 1);
      chk("ren_low_after", o_mem_ren, 0);
      chk("fill_rdata", o_cpu_rdata, 32'h1000_0000 + a);
      @(negedge clk);
      chk("miss_cnt", o_miss_count, em);
      chk("hit_cnt", o_hit_count, eh);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_ren", o_mem_ren, 0);
      chk("rst_baddr", o_mem_block_address, 0);
      chk("rst_hit", o_hit_count, 0);
      chk("rst_miss", o_miss_count, 0);
      chk("rst_stall_idle", o_cpu_stall, 0);
      i_cpu_req = 1'b1;
      #1;
      chk("rst_stall_req", o_cpu_stall, 1);
      @(negedge clk);
      i_cpu_req = 1'b0;
      i_rst_n   = 1'b1;
      @(negedge clk);

      // Cold miss
      do_miss(8'h00, 5'h00, 1'b0, 1, 1);

      // Spatial hits 01..07 back to back
      for (int a = 1; a < 8; a++) begin
         i_cpu_addr = a[7:0];
         #1;
         chk("sp_stall", o_cpu_stall, 0);
         chk("sp_rdata", o_cpu_rdata, 32'h1000_0000 + a);
         chk("sp_ren", o_mem_ren, 0);
         @(negedge clk);
      end
      i_cpu_req = 1'b0;
      chk("sp_hit_cnt", o_hit_count, 8);

      // Conflict eviction on index 0
      do_miss(8'h20, 5'h04, 1'b0, 2, 9);
      do_miss(8'h00, 5'h00, 1'b0, 3, 10);
      do_miss(8'h20, 5'h04, 1'b0, 4, 11);

      // Consecutive misses: handshake hygiene
      do_miss(8'h08, 5'h01, 1'b0, 5, 12);
      do_miss(8'h10, 5'h02, 1'b0, 6, 13);

      // Flush in IDLE
      do_miss(8'h00, 5'h00, 1'b0, 7, 14);
      i_flush = 1'b1;
      #1;
      chk("fl_pre_stall", o_cpu_stall, 0);
      @(negedge clk);
      i_flush = 1'b0;
      #1;
      chk("fl_hit_cnt", o_hit_count, 14);
      chk("fl_miss_cnt", o_miss_count, 7);
      chk("fl_post_stall", o_cpu_stall, 1);
      do_miss(8'h00, 5'h00, 1'b0, 8, 15);

      // Flush during REQ: only the filled line survives
      do_miss(8'h18, 5'h03, 1'b1, 9, 16);
      chk("frq_l3_stall", o_cpu_stall, 0);
      i_cpu_addr = 8'h00; #1;
      chk("frq_l0_stall", o_cpu_stall, 1);
      i_cpu_addr = 8'h08; #1;
      chk("frq_l1_stall", o_cpu_stall, 1);
      i_cpu_addr = 8'h10; #1;
      chk("frq_l2_stall", o_cpu_stall, 1);
      i_cpu_req = 1'b0;
      @(negedge clk);
      chk("frq_miss_cnt", o_miss_count, 9);

      // Reset during REQ
      i_cpu_req  = 1'b1;
      i_cpu_addr = 8'h28;
      @(negedge clk);
      chk("rm_ren", o_mem_ren, 1);
      chk("rm_baddr", o_mem_block_address, 5'h05);
      i_rst_n   = 1'b0;
      i_cpu_req = 1'b0;
      #1;
      chk("rm_ren_drop", o_mem_ren, 0);
      chk("rm_baddr_clr", o_mem_block_address, 0);
      chk("rm_hit_clr", o_hit_count, 0);
      chk("rm_miss_clr", o_miss_count, 0);
      @(negedge clk);
      i_rst_n = 1'b1;
      @(negedge clk);
      chk("rm_hit_idle", o_hit_count, 0);
      chk("rm_miss_idle", o_miss_count, 0);
      do_miss(8'h28, 5'h05, 1'b0, 1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
